integer_issue_queue: RTL and testbench

INTEGER_ISSUE_QUEUE -- requirements
Module: integer_issue_queue

---
 rtl/integer_issue_queue.sv | 157 +++++++++++++++
 tb/tb_integer_issue_queue.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/integer_issue_queue.sv
// Integer issue queue: holds renamed ops until both operands are ready, wakes operands from the CDB, and issues one op per cycle.
// Optional INTEGER_ISSUE_AGE_ORDER_EN selects the oldest eligible entry; by default the lowest-index eligible entry is selected.
module integer_issue_queue #(
    parameter int XLEN                = 32,
    parameter int ROB_INDEX_WIDTH     = 8,
    parameter int DECODED_INSTR_WIDTH = 8,
    parameter int DEPTH               = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           alloc_valid,
    output logic                           alloc_ready,
    input  logic                           alloc_1st_ready,
    input  logic [XLEN-1:0]                alloc_1st_reg,
    input  logic                           alloc_2nd_ready,
    input  logic [XLEN-1:0]                alloc_2nd_reg,
    input  logic [DECODED_INSTR_WIDTH-1:0] alloc_decoded_instruction,
    input  logic [ROB_INDEX_WIDTH-1:0]     alloc_ROB_index,
    input  logic [XLEN-1:0]                alloc_PC_i,
    input  logic                           cdb_valid,
    input  logic [ROB_INDEX_WIDTH-1:0]     cdb_ROB_index,
    input  logic [XLEN-1:0]                cdb_value,
    output logic                           issue_valid,
    input  logic                           issue_ready,
    output logic [XLEN-1:0]                issue_1st_reg,
    output logic [XLEN-1:0]                issue_2nd_reg,
    output logic [DECODED_INSTR_WIDTH-1:0] issue_decoded_instruction,
    output logic [ROB_INDEX_WIDTH-1:0]     issue_ROB_index,
    output logic [XLEN-1:0]                issue_PC_i
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]               ent_valid;
    logic [DEPTH-1:0]               ent_1st_ready;
    logic [DEPTH-1:0]               ent_2nd_ready;
    logic [XLEN-1:0]                ent_1st_reg [DEPTH];
    logic [XLEN-1:0]                ent_2nd_reg [DEPTH];
    logic [DECODED_INSTR_WIDTH-1:0] ent_instr   [DEPTH];
    logic [ROB_INDEX_WIDTH-1:0]     ent_rob     [DEPTH];
    logic [XLEN-1:0]                ent_pc      [DEPTH];

    logic [DEPTH-1:0] eligible;
    logic [DEPTH-1:0] wake_1st;
    logic [DEPTH-1:0] wake_2nd;
    logic [IDX_W-1:0] alloc_slot;
    logic [IDX_W-1:0] issue_sel;
    logic             alloc_fire;
    logic             issue_fire;
    logic             alloc_1st_wake;
    logic             alloc_2nd_wake;

    assign alloc_ready = ~&ent_valid;
    assign eligible    = ent_valid & ent_1st_ready & ent_2nd_ready;
    assign issue_valid = |eligible;
    assign alloc_fire  = alloc_valid && alloc_ready && !flush;
    assign issue_fire  = issue_valid && issue_ready && !flush;

    // Waiting operands carry their producer's ROB tag in the low bits.
    assign alloc_1st_wake = cdb_valid && !alloc_1st_ready
                         && (alloc_1st_reg[ROB_INDEX_WIDTH-1:0] == cdb_ROB_index);
    assign alloc_2nd_wake = cdb_valid && !alloc_2nd_ready
                         && (alloc_2nd_reg[ROB_INDEX_WIDTH-1:0] == cdb_ROB_index);

    always_comb begin
        wake_1st = '0;
        wake_2nd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wake_1st[i] = cdb_valid && ent_valid[i] && !ent_1st_ready[i]
                       && (ent_1st_reg[i][ROB_INDEX_WIDTH-1:0] == cdb_ROB_index);
            wake_2nd[i] = cdb_valid && ent_valid[i] && !ent_2nd_ready[i]
                       && (ent_2nd_reg[i][ROB_INDEX_WIDTH-1:0] == cdb_ROB_index);
        end
    end

    always_comb begin
        alloc_slot = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_valid[i]) alloc_slot = IDX_W'(i);
        end
    end

`ifdef INTEGER_ISSUE_AGE_ORDER_EN
    // ent_older[i] marks the slots that were allocated before slot i and are still resident.
    logic [DEPTH-1:0] ent_older [DEPTH];
    logic [DEPTH-1:0] blocked;

    always_comb begin
        issue_sel = '0;
        blocked   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            blocked[i] = |(eligible & ent_older[i]);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (eligible[i] && !blocked[i]) issue_sel = IDX_W'(i);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) ent_older[i] <= '0;
        end else if (alloc_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (IDX_W'(i) == alloc_slot) ent_older[i] <= ent_valid;
                else                         ent_older[i][alloc_slot] <= 1'b0;
            end
        end
    end
`else
    always_comb begin
        issue_sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (eligible[i]) issue_sel = IDX_W'(i);
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            ent_valid     <= '0;
            ent_1st_ready <= '0;
            ent_2nd_ready <= '0;
        end else if (flush) begin
            ent_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wake_1st[i]) begin
                    ent_1st_ready[i] <= 1'b1;
                    ent_1st_reg[i]   <= cdb_value;
                end
                if (wake_2nd[i]) begin
                    ent_2nd_ready[i] <= 1'b1;
                    ent_2nd_reg[i]   <= cdb_value;
                end
            end
            if (issue_fire) ent_valid[issue_sel] <= 1'b0;
            // The alloc slot is never valid, so it cannot collide with a wakeup or the issue slot.
            if (alloc_fire) begin
                ent_valid[alloc_slot]     <= 1'b1;
                ent_1st_ready[alloc_slot] <= alloc_1st_ready || alloc_1st_wake;
                ent_2nd_ready[alloc_slot] <= alloc_2nd_ready || alloc_2nd_wake;
                ent_1st_reg[alloc_slot]   <= alloc_1st_wake ? cdb_value : alloc_1st_reg;
                ent_2nd_reg[alloc_slot]   <= alloc_2nd_wake ? cdb_value : alloc_2nd_reg;
                ent_instr[alloc_slot]     <= alloc_decoded_instruction;
                ent_rob[alloc_slot]       <= alloc_ROB_index;
                ent_pc[alloc_slot]        <= alloc_PC_i;
            end
        end
    end

    assign issue_1st_reg             = issue_valid ? ent_1st_reg[issue_sel] : '0;
    assign issue_2nd_reg             = issue_valid ? ent_2nd_reg[issue_sel] : '0;
    assign issue_decoded_instruction = issue_valid ? ent_instr[issue_sel]   : '0;
    assign issue_ROB_index           = issue_valid ? ent_rob[issue_sel]     : '0;
    assign issue_PC_i                = issue_valid ? ent_pc[issue_sel]      : '0;

endmodule

// File: tb/tb_integer_issue_queue.sv
// Bench for integer_issue_queue: directed scenarios plus randomized traffic checked against a slot/age reference model.
module tb_integer_issue_queue;
    localparam int XLEN  = 32;
    localparam int RW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic            clock = 1'b0;
    logic            reset, flush;
    logic            alloc_valid, alloc_ready;
    logic            alloc_1st_ready, alloc_2nd_ready;
    logic [XLEN-1:0] alloc_1st_reg, alloc_2nd_reg, alloc_PC_i;
    logic [DW-1:0]   alloc_decoded_instruction;
    logic [RW-1:0]   alloc_ROB_index;
    logic            cdb_valid;
    logic [RW-1:0]   cdb_ROB_index;
    logic [XLEN-1:0] cdb_value;
    logic            issue_valid, issue_ready;
    logic [XLEN-1:0] issue_1st_reg, issue_2nd_reg, issue_PC_i;
    logic [DW-1:0]   issue_decoded_instruction;
    logic [RW-1:0]   issue_ROB_index;

    integer_issue_queue #(.XLEN(XLEN), .ROB_INDEX_WIDTH(RW), .DECODED_INSTR_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_1st_ready(alloc_1st_ready), .alloc_1st_reg(alloc_1st_reg),
        .alloc_2nd_ready(alloc_2nd_ready), .alloc_2nd_reg(alloc_2nd_reg),
        .alloc_decoded_instruction(alloc_decoded_instruction),
        .alloc_ROB_index(alloc_ROB_index), .alloc_PC_i(alloc_PC_i),
        .cdb_valid(cdb_valid), .cdb_ROB_index(cdb_ROB_index), .cdb_value(cdb_value),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_1st_reg(issue_1st_reg), .issue_2nd_reg(issue_2nd_reg),
        .issue_decoded_instruction(issue_decoded_instruction),
        .issue_ROB_index(issue_ROB_index), .issue_PC_i(issue_PC_i)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: one record per slot plus an allocation sequence number for age.
    bit              m_valid [DEPTH];
    bit              m_r1    [DEPTH];
    bit              m_r2    [DEPTH];
    logic [XLEN-1:0] m_v1    [DEPTH];
    logic [XLEN-1:0] m_v2    [DEPTH];
    logic [DW-1:0]   m_op    [DEPTH];
    logic [RW-1:0]   m_rob   [DEPTH];
    logic [XLEN-1:0] m_pc    [DEPTH];
    int              m_seq   [DEPTH];
    int              seq_ctr = 0;

    function automatic int model_free_slot();
        for (int i = 0; i < DEPTH; i++) if (!m_valid[i]) return i;
        return -1;
    endfunction

    function automatic int model_select();
        int best;
        best = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_valid[i] && m_r1[i] && m_r2[i]) begin
`ifdef INTEGER_ISSUE_AGE_ORDER_EN
                if (best < 0 || m_seq[i] < m_seq[best]) best = i;
`else
                if (best < 0) best = i;
`endif
            end
        end
        return best;
    endfunction

    // Apply the current inputs to the model, then advance one clock.
    task automatic step();
        int sel, slot;
        sel  = model_select();
        slot = model_free_slot();
        if (reset || flush) begin
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
        end else begin
            if (cdb_valid) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (m_valid[i] && !m_r1[i] && m_v1[i][RW-1:0] == cdb_ROB_index) begin
                        m_r1[i] = 1; m_v1[i] = cdb_value;
                    end
                    if (m_valid[i] && !m_r2[i] && m_v2[i][RW-1:0] == cdb_ROB_index) begin
                        m_r2[i] = 1; m_v2[i] = cdb_value;
                    end
                end
            end
            if (sel >= 0 && issue_ready) m_valid[sel] = 0;
            if (alloc_valid && slot >= 0) begin
                m_valid[slot] = 1;
                m_r1[slot] = alloc_1st_ready; m_v1[slot] = alloc_1st_reg;
                m_r2[slot] = alloc_2nd_ready; m_v2[slot] = alloc_2nd_reg;
                if (cdb_valid && !alloc_1st_ready && alloc_1st_reg[RW-1:0] == cdb_ROB_index) begin
                    m_r1[slot] = 1; m_v1[slot] = cdb_value;
                end
                if (cdb_valid && !alloc_2nd_ready && alloc_2nd_reg[RW-1:0] == cdb_ROB_index) begin
                    m_r2[slot] = 1; m_v2[slot] = cdb_value;
                end
                m_op[slot] = alloc_decoded_instruction;
                m_rob[slot] = alloc_ROB_index;
                m_pc[slot] = alloc_PC_i;
                m_seq[slot] = seq_ctr;
                seq_ctr++;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        reset = 0; flush = 0; alloc_valid = 0; issue_ready = 0; cdb_valid = 0;
        alloc_1st_ready = 0; alloc_1st_reg = '0; alloc_2nd_ready = 0; alloc_2nd_reg = '0;
        alloc_decoded_instruction = '0; alloc_ROB_index = '0; alloc_PC_i = '0;
        cdb_ROB_index = '0; cdb_value = '0;
    endtask

    task automatic set_alloc(input logic [RW-1:0] rob, input bit r1, input logic [XLEN-1:0] v1,
                             input bit r2, input logic [XLEN-1:0] v2, input logic [DW-1:0] op,
                             input logic [XLEN-1:0] pc);
        alloc_valid = 1; alloc_ROB_index = rob;
        alloc_1st_ready = r1; alloc_1st_reg = v1;
        alloc_2nd_ready = r2; alloc_2nd_reg = v2;
        alloc_decoded_instruction = op; alloc_PC_i = pc;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1;
        step();
        step();
        reset = 0;
        checks++;
        if (alloc_ready !== 1'b1) begin
            errors++; $display("FAIL reset_alloc_ready: got %0b want 1", alloc_ready);
        end
        checks++;
        if (issue_valid !== 1'b0) begin
            errors++; $display("FAIL reset_issue_valid: got %0b want 0", issue_valid);
        end
    endtask

    task automatic test_basic_issue();
        drive_idle();
        set_alloc(8'd11, 1, 32'd17, 1, 32'd18, 8'd0, 32'h100);
        step();
        alloc_valid = 0; issue_ready = 1;
        checks++;
        if (issue_valid !== 1'b1 || issue_1st_reg !== 32'd17 || issue_2nd_reg !== 32'd18
            || issue_ROB_index !== 8'd11 || issue_PC_i !== 32'h100) begin
            errors++;
            $display("FAIL basic_issue: got v=%0b a=%0d b=%0d rob=%0d pc=%h want v=1 a=17 b=18 rob=11 pc=100",
                     issue_valid, issue_1st_reg, issue_2nd_reg, issue_ROB_index, issue_PC_i);
        end
        step();
        issue_ready = 0;
        checks++;
        if (issue_valid !== 1'b0 || alloc_ready !== 1'b1) begin
            errors++; $display("FAIL basic_empty: got iv=%0b ar=%0b want iv=0 ar=1", issue_valid, alloc_ready);
        end
    endtask

    task automatic test_wakeup();
        drive_idle();
        issue_ready = 1;
        set_alloc(8'd12, 0, 32'd5, 1, 32'd9, 8'd3, 32'h200);
        step();
        alloc_valid = 0;
        checks++;
        if (issue_valid !== 1'b0) begin
            errors++; $display("FAIL wakeup_wait1: got iv=%0b want 0", issue_valid);
        end
        step();
        checks++;
        if (issue_valid !== 1'b0) begin
            errors++; $display("FAIL wakeup_wait2: got iv=%0b want 0", issue_valid);
        end
        cdb_valid = 1; cdb_ROB_index = 8'd5; cdb_value = 32'd100;
        step();
        cdb_valid = 0;
        checks++;
        if (issue_valid !== 1'b1 || issue_1st_reg !== 32'd100 || issue_2nd_reg !== 32'd9 || issue_ROB_index !== 8'd12) begin
            errors++;
            $display("FAIL wakeup_issue: got iv=%0b a=%0d b=%0d rob=%0d want iv=1 a=100 b=9 rob=12",
                     issue_valid, issue_1st_reg, issue_2nd_reg, issue_ROB_index);
        end
        step();
        issue_ready = 0;
    endtask

    task automatic test_same_cycle_wakeup();
        drive_idle();
        set_alloc(8'd13, 1, 32'd1, 0, 32'd7, 8'd4, 32'h300);
        cdb_valid = 1; cdb_ROB_index = 8'd7; cdb_value = 32'd42;
        step();
        alloc_valid = 0; cdb_valid = 0; issue_ready = 1;
        checks++;
        if (issue_valid !== 1'b1 || issue_2nd_reg !== 32'd42 || issue_ROB_index !== 8'd13) begin
            errors++;
            $display("FAIL same_cycle_wakeup: got iv=%0b b=%0d rob=%0d want iv=1 b=42 rob=13",
                     issue_valid, issue_2nd_reg, issue_ROB_index);
        end
        step();
        issue_ready = 0;
    endtask

    task automatic test_full();
        drive_idle();
        for (int i = 0; i < DEPTH; i++) begin
            set_alloc(RW'(30 + i), 1, 32'(i), 1, 32'(i + 50), 8'd1, 32'(i * 4));
            step();
        end
        checks++;
        if (alloc_ready !== 1'b0) begin
            errors++; $display("FAIL full_alloc_ready: got %0b want 0", alloc_ready);
        end
        set_alloc(8'd99, 1, 32'd0, 1, 32'd0, 8'd0, 32'd0);
        issue_ready = 1;
        step();
        alloc_valid = 0; issue_ready = 0;
        checks++;
        if (alloc_ready !== 1'b1) begin
            errors++; $display("FAIL full_freed_slot: got %0b want 1", alloc_ready);
        end
        issue_ready = 1;
        for (int i = 0; i < DEPTH - 1; i++) begin
            checks++;
            if (issue_ROB_index === 8'd99) begin
                errors++; $display("FAIL full_dropped_alloc: got rob=%0d want not 99", issue_ROB_index);
            end
            step();
        end
        checks++;
        if (issue_valid !== 1'b0) begin
            errors++; $display("FAIL full_drain: got iv=%0b want 0", issue_valid);
        end
        issue_ready = 0;
    endtask

    task automatic test_age_order();
        logic [RW-1:0] want;
`ifdef INTEGER_ISSUE_AGE_ORDER_EN
        want = 8'd20;
`else
        want = 8'd21;
`endif
        drive_idle();
        set_alloc(8'd1, 1, 32'd1, 1, 32'd1, 8'd0, 32'h0);
        step();
        set_alloc(8'd2, 0, 32'd50, 1, 32'd1, 8'd0, 32'h4);
        step();
        set_alloc(8'd20, 0, 32'd40, 1, 32'd2, 8'd0, 32'h8);
        step();
        alloc_valid = 0; issue_ready = 1;
        step();
        issue_ready = 0;
        set_alloc(8'd21, 0, 32'd40, 1, 32'd3, 8'd0, 32'hc);
        step();
        alloc_valid = 0;
        cdb_valid = 1; cdb_ROB_index = 8'd40; cdb_value = 32'd7;
        step();
        cdb_valid = 0;
        checks++;
        if (issue_valid !== 1'b1 || issue_ROB_index !== want || issue_1st_reg !== 32'd7) begin
            errors++;
            $display("FAIL age_order: got iv=%0b rob=%0d a=%0d want iv=1 rob=%0d a=7",
                     issue_valid, issue_ROB_index, issue_1st_reg, want);
        end
        flush = 1;
        step();
        flush = 0;
    endtask

    task automatic test_flush();
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            set_alloc(RW'(60 + i), 1, 32'd5, 1, 32'd6, 8'd2, 32'h40);
            step();
        end
        set_alloc(8'd77, 1, 32'd8, 1, 32'd9, 8'd2, 32'h80);
        flush = 1; issue_ready = 1;
        step();
        flush = 0; alloc_valid = 0;
        checks++;
        if (issue_valid !== 1'b0 || alloc_ready !== 1'b1) begin
            errors++; $display("FAIL flush_state: got iv=%0b ar=%0b want iv=0 ar=1", issue_valid, alloc_ready);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (issue_valid !== 1'b0) begin
                errors++; $display("FAIL flush_no_issue: got iv=%0b rob=%0d want iv=0", issue_valid, issue_ROB_index);
            end
        end
        issue_ready = 0;
    endtask

    task automatic test_random();
        int sel;
        bit exp_ar, exp_iv;
        drive_idle();
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 39) == 0);
            alloc_valid = ($urandom_range(0, 2) != 0);
            alloc_ROB_index = RW'($urandom_range(0, 15));
            alloc_1st_ready = $urandom_range(0, 1);
            alloc_2nd_ready = $urandom_range(0, 1);
            alloc_1st_reg = alloc_1st_ready ? $urandom : {$urandom_range(0, 255), 16'h0, RW'($urandom_range(0, 15))};
            alloc_2nd_reg = alloc_2nd_ready ? $urandom : {$urandom_range(0, 255), 16'h0, RW'($urandom_range(0, 15))};
            alloc_decoded_instruction = DW'($urandom);
            alloc_PC_i = $urandom;
            cdb_valid = $urandom_range(0, 1);
            cdb_ROB_index = RW'($urandom_range(0, 15));
            cdb_value = $urandom;
            issue_ready = ($urandom_range(0, 3) != 0);
            #1;
            sel = model_select();
            exp_iv = (sel >= 0);
            exp_ar = (model_free_slot() >= 0);
            checks++;
            if (alloc_ready !== exp_ar) begin
                errors++; $display("FAIL rand_alloc_ready c=%0d: got %0b want %0b", c, alloc_ready, exp_ar);
            end
            checks++;
            if (issue_valid !== exp_iv) begin
                errors++; $display("FAIL rand_issue_valid c=%0d: got %0b want %0b", c, issue_valid, exp_iv);
            end
            if (exp_iv) begin
                checks++;
                if (issue_ROB_index !== m_rob[sel] || issue_1st_reg !== m_v1[sel] || issue_2nd_reg !== m_v2[sel]
                    || issue_decoded_instruction !== m_op[sel] || issue_PC_i !== m_pc[sel]) begin
                    errors++;
                    $display("FAIL rand_issue_data c=%0d: got rob=%0d a=%h b=%h op=%h pc=%h want rob=%0d a=%h b=%h op=%h pc=%h",
                             c, issue_ROB_index, issue_1st_reg, issue_2nd_reg, issue_decoded_instruction, issue_PC_i,
                             m_rob[sel], m_v1[sel], m_v2[sel], m_op[sel], m_pc[sel]);
                end
            end
            step();
        end
        drive_idle();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
        drive_idle();
        @(posedge clock);
        #1;
        test_reset();
        test_basic_issue();
        test_wakeup();
        test_same_cycle_wakeup();
        test_full();
        test_age_order();
        test_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
